// File: rtl/counter_ctrl_if.sv
// Button, digit-value and control signals between the board/counter side and counter_ctrl.
// master drives buttons and digit values; slave is the sequencer.
interface counter_ctrl_if;
  logic       pb_start;
  logic       pb_set;
  logic       pb_inc;
  logic [3:0] ones_num;
  logic [3:0] tens_num;
  logic       ones_en;
  logic       ones_pls;
  logic       tens_en;
  logic       tens_pls;
  logic [1:0] state;
  logic       sel;

  modport master (
    output pb_start, pb_set, pb_inc, ones_num, tens_num,
    input  ones_en, ones_pls, tens_en, tens_pls, state, sel
  );

  modport slave (
    input  pb_start, pb_set, pb_inc, ones_num, tens_num,
    output ones_en, ones_pls, tens_en, tens_pls, state, sel
  );
endinterface

// File: rtl/counter_ctrl.sv
// Run/pause/set sequencer for a two-digit decimal display: debounces three buttons,
// runs the tick prescaler and drives the ones/tens enables and increment strobes.
module counter_ctrl #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned DB_LEN = 4
) (
  input logic           clk,
  input logic           rst_n,
  counter_ctrl_if.slave bus
);
  localparam int unsigned NB = 3;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    SET   = 2'b11
  } state_e;

  // Button order in all vectors: bit 0 start, bit 1 set, bit 2 inc.
  logic [NB-1:0]         raw;
  logic [NB-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]         lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
  logic [NB-1:0]         pulse_q, pulse_d;
  logic [NB-1:0][CW-1:0] db_cnt_q, db_cnt_d;

  logic unused_tens;

  assign raw         = {bus.pb_inc, bus.pb_set, bus.pb_start};
  assign unused_tens = ^bus.tens_num;

  // Synchronize, debounce and edge-detect each button.
  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    pulse_d    = lvl_q & ~lvl_prev_q;
    db_cnt_d   = '0;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == CW'(DB_LEN - 1)) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      pulse_q    <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      pulse_q    <= pulse_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ones_en_q, ones_en_d, tens_en_q, tens_en_d;
  logic          ones_pls_q, ones_pls_d, tens_pls_q, tens_pls_d;
  logic          tick;
  logic          start_p, set_p, inc_p;

  assign start_p = pulse_q[0];
  assign set_p   = pulse_q[1];
  assign inc_p   = pulse_q[2];

  // Next state, prescaler and registered outputs; start > set > inc.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    presc_d    = '0;
    tick       = 1'b0;
    ones_pls_d = 1'b0;
    tens_pls_d = 1'b0;

    if (state_q == RUN) begin
      tick    = (presc_q == PW'(DIV - 1));
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      ones_pls_d = 1'b1;
      tens_pls_d = (bus.ones_num == 4'd9);
    end

    unique case (state_q)
      IDLE, PAUSE: begin
        if (start_p) begin
          state_d = RUN;
        end else if (set_p) begin
          state_d = SET;
          sel_d   = 1'b0;
        end
      end
      RUN: begin
        if (start_p) state_d = PAUSE;
      end
      SET: begin
        if (start_p) begin
          state_d = RUN;
          sel_d   = 1'b0;
        end else if (set_p) begin
          if (!sel_q) begin
            sel_d = 1'b1;
          end else begin
            state_d = PAUSE;
            sel_d   = 1'b0;
          end
        end else if (inc_p) begin
          ones_pls_d = ~sel_q;
          tens_pls_d = sel_q;
        end
      end
      default: ;
    endcase

    ones_en_d = (state_d == RUN) || ((state_d == SET) && !sel_d);
    tens_en_d = (state_d == RUN) || ((state_d == SET) && sel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      presc_q    <= '0;
      ones_en_q  <= 1'b0;
      tens_en_q  <= 1'b0;
      ones_pls_q <= 1'b0;
      tens_pls_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      presc_q    <= presc_d;
      ones_en_q  <= ones_en_d;
      tens_en_q  <= tens_en_d;
      ones_pls_q <= ones_pls_d;
      tens_pls_q <= tens_pls_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.sel      = sel_q;
  assign bus.ones_en  = ones_en_q;
  assign bus.tens_en  = tens_en_q;
  assign bus.ones_pls = ones_pls_q;
  assign bus.tens_pls = tens_pls_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a behavioural model of the sequencer.
module tb_counter_ctrl;
  localparam int DIV = 4;
  localparam int DB  = 4;

  logic clk;
  logic rst_n;
  counter_ctrl_if bus ();

  counter_ctrl #(.DIV(DIV), .DB_LEN(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int cnt_ones = 0;
  int cnt_tens = 0;
  int ones_cnt = 0;
  bit track_num = 1'b0;

  // Model: raw sample history per button (index 0 newest), accepted levels, press pulses.
  logic [DB+1:0] hist [3];
  bit   m_lvl [3];
  bit   m_lvl_prev [3];
  bit   m_pulse [3];
  int   m_st, m_sel, m_run_k;
  bit   e_ones_pls, e_tens_pls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      hist[b] = '0; m_lvl[b] = 1'b0; m_lvl_prev[b] = 1'b0; m_pulse[b] = 1'b0;
    end
    m_st = 0; m_sel = 0; m_run_k = 0;
    e_ones_pls = 1'b0; e_tens_pls = 1'b0;
  endtask

  task automatic model_step();
    bit p [3];
    bit raw [3];
    bit tick, all_diff;
    int ns, nsel;
    raw[0] = bus.pb_start; raw[1] = bus.pb_set; raw[2] = bus.pb_inc;
    for (int b = 0; b < 3; b++) p[b] = m_pulse[b];

    // Sequencer: a tick closes every DIV-th cycle spent in RUN.
    tick = (m_st == 1) && (((m_run_k + 1) % DIV) == 0);
    ns = m_st; nsel = m_sel;
    e_ones_pls = tick;
    e_tens_pls = tick && (bus.ones_num == 4'd9);
    case (m_st)
      0, 2: if (p[0]) ns = 1; else if (p[1]) begin ns = 3; nsel = 0; end
      1:    if (p[0]) ns = 2;
      default: begin
        if (p[0]) begin ns = 1; nsel = 0; end
        else if (p[1]) begin
          if (m_sel == 0) nsel = 1; else begin ns = 2; nsel = 0; end
        end else if (p[2]) begin
          if (m_sel == 1) e_tens_pls = 1'b1; else e_ones_pls = 1'b1;
        end
      end
    endcase
    m_run_k = (ns == 1 && m_st == 1) ? m_run_k + 1 : 0;
    m_st = ns; m_sel = nsel;

    // Buttons: level flips once the last DB synchronized samples all disagree with it.
    for (int b = 0; b < 3; b++) begin
      m_pulse[b]    = m_lvl[b] && !m_lvl_prev[b];
      m_lvl_prev[b] = m_lvl[b];
      hist[b] = {hist[b][DB:0], raw[b]};
      all_diff = 1'b1;
      for (int i = 2; i <= DB + 1; i++) if (hist[b][i] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) m_lvl[b] = !m_lvl[b];
    end
  endtask

  task automatic compare_all();
    check("state",    bus.state,    m_st);
    check("sel",      bus.sel,      m_sel);
    check("ones_en",  bus.ones_en,  (m_st == 1) || (m_st == 3 && m_sel == 0));
    check("tens_en",  bus.tens_en,  (m_st == 1) || (m_st == 3 && m_sel == 1));
    check("ones_pls", bus.ones_pls, e_ones_pls);
    check("tens_pls", bus.tens_pls, e_tens_pls);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
    if (bus.ones_pls) cnt_ones++;
    if (bus.tens_pls) cnt_tens++;
    if (track_num) begin
      if (e_ones_pls) ones_cnt = (ones_cnt >= 9) ? 0 : ones_cnt + 1;
      bus.ones_num = 4'(ones_cnt);
    end else begin
      bus.ones_num = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
    end
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic [2:0] mask, input int len, input int gap);
    bus.pb_start = mask[0]; bus.pb_set = mask[1]; bus.pb_inc = mask[2];
    hold(len);
    bus.pb_start = 1'b0; bus.pb_set = 1'b0; bus.pb_inc = 1'b0;
    hold(gap);
  endtask

  task automatic wait_strobe(input int limit);
    int n;
    n = 0;
    do begin step(); n++; end while (!(bus.ones_pls || bus.tens_pls) && n < limit);
    if (!(bus.ones_pls || bus.tens_pls)) check("strobe_timeout", 0, 1);
  endtask

  // Press start from a stopped state; check press latency and first tick distance.
  task automatic start_and_time(input string tag);
    int t0, t_run;
    t0 = cyc; t_run = 0;
    bus.pb_start = 1'b1;
    for (int e = 0; e < 20 && t_run == 0; e++) begin
      step();
      if (bus.state == 2'b01) t_run = cyc;
    end
    bus.pb_start = 1'b0;
    check({tag, "_press_lat"}, t_run - t0, DB + 4);
    wait_strobe(3 * DIV);
    check({tag, "_first_tick"}, cyc - t_run, DIV);
  endtask

  initial begin
    int c0, t0;
    rst_n = 1'b0;
    bus.pb_start = 1'b0; bus.pb_set = 1'b0; bus.pb_inc = 1'b0;
    bus.ones_num = 4'd0; bus.tens_num = 4'd0;
    model_reset();
    hold(3);
    check("reset_state", bus.state, 0);
    rst_n = 1'b1;
    hold(4);

    // Short glitch must not reach the FSM.
    press(3'b001, DB - 1, 12);
    check("glitch_state", bus.state, 0);

    // Start, tick latency, period and carry from 8 -> 9 -> 0.
    track_num = 1'b1; ones_cnt = 8; bus.ones_num = 4'd8;
    start_and_time("run");
    t0 = cyc;
    wait_strobe(3 * DIV);
    check("tick_period", cyc - t0, DIV);
    check("carry_ones", bus.ones_pls, 1);
    check("carry_tens", bus.tens_pls, 1);
    check("carry_wrap", ones_cnt, 0);

    // Stop, idle while paused, then resume with a full period.
    press(3'b001, 10, 12);
    check("pause_state", bus.state, 2);
    c0 = cnt_ones + cnt_tens;
    hold(10);
    check("pause_no_strobe", cnt_ones + cnt_tens - c0, 0);
    start_and_time("resume");

    // Asynchronous reset in the middle of RUN.
    hold(2);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    hold(3);
    rst_n = 1'b1;
    hold(6);
    check("post_reset_state", bus.state, 0);

    // Manual set sequence.
    press(3'b010, 10, 12);
    check("set_state", bus.state, 3);
    check("set_ones_en", bus.ones_en, 1);
    check("set_tens_en", bus.tens_en, 0);
    c0 = cnt_ones; t0 = cnt_tens;
    press(3'b100, 10, 12);
    check("set_inc_ones", cnt_ones - c0, 1);
    check("set_inc_no_tens", cnt_tens - t0, 0);
    press(3'b010, 10, 12);
    check("set_sel1", bus.sel, 1);
    c0 = cnt_ones; t0 = cnt_tens;
    press(3'b100, 10, 12);
    check("set_inc_tens", cnt_tens - t0, 1);
    check("set_inc_no_ones", cnt_ones - c0, 0);
    press(3'b010, 10, 12);
    check("set_exit_pause", bus.state, 2);
    check("pause_en", {bus.ones_en, bus.tens_en}, 0);

    // Start and inc coincident in SET: start wins, no manual strobe.
    press(3'b010, 10, 12);
    c0 = cnt_ones + cnt_tens;
    bus.pb_start = 1'b1; bus.pb_inc = 1'b1;
    for (int e = 0; e < 20 && bus.state != 2'b01; e++) step();
    bus.pb_start = 1'b0; bus.pb_inc = 1'b0;
    check("prio_state", bus.state, 1);
    check("prio_no_strobe", cnt_ones + cnt_tens - c0, 0);
    hold(12);

    // Random button traffic with random digit values and rare resets.
    track_num = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.pb_start = ~bus.pb_start;
      if ($urandom_range(0, 7) == 0) bus.pb_set   = ~bus.pb_set;
      if ($urandom_range(0, 7) == 0) bus.pb_inc   = ~bus.pb_inc;
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
